pwm_downcount_compare: RTL and testbench

PWM_DOWNCOUNT_COMPARE -- requirements
Module: pwm_downcount_compare

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_duty_shadow.sv | 45 ++++
 rtl/pwm_downcount_compare.sv | 80 ++++++++
 tb/tb_pwm_downcount_compare.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the down-count compare PWM block.
// Holds the controller state encoding and the period/MAX helpers derived from WIDTH.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } pwm_state_e;

    localparam int unsigned DEFAULT_WIDTH = 3;

    function automatic int unsigned pwm_period(input int unsigned width);
        return 32'd1 << width;
    endfunction

    function automatic int unsigned pwm_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    localparam int unsigned DEFAULT_PERIOD = pwm_period(DEFAULT_WIDTH);
    localparam int unsigned DEFAULT_MAX    = pwm_max(DEFAULT_WIDTH);

endpackage

// File: rtl/pwm_duty_shadow.sv
// One-deep pending duty register in front of the active duty, with ready/valid intake.
// A pending value is promoted only at a period start, so a period never changes duty mid-way.
module pwm_duty_shadow
    import pwm_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [WIDTH:0] duty_in,
    input  logic           duty_valid,
    output logic           duty_ready,
    output logic [WIDTH:0] eff_duty
);

    localparam logic [WIDTH:0] PERIOD = (WIDTH+1)'(pwm_period(WIDTH));

    logic           pend_full;
    logic [WIDTH:0] pend_duty;
    logic [WIDTH:0] active_duty;
    logic [WIDTH:0] clamped;

    assign duty_ready = ~pend_full;
    assign clamped    = (duty_in > PERIOD) ? PERIOD : duty_in;

    // Duty seen by the compare on the start edge itself, so the new value covers count = MAX.
    assign eff_duty = (start && pend_full) ? pend_duty : active_duty;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full   <= 1'b0;
            pend_duty   <= '0;
            active_duty <= '0;
        end else if (start && pend_full) begin
            active_duty <= pend_duty;
            pend_full   <= 1'b0;
        end else if (duty_valid && duty_ready) begin
            pend_duty <= clamped;
            pend_full <= 1'b1;
        end
    end

endmodule

// File: rtl/pwm_downcount_compare.sv
// PWM generator that compares an external free-running down-counter against a duty value.
// Holds the run/arm controller, period-start detection, registered compare and period counter.
module pwm_downcount_compare
    import pwm_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  count,
    input  logic              en,
    input  logic [WIDTH:0]    duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm,
    output logic              period_start,
    output logic [PCNT_W-1:0] period_cnt
);

    localparam logic [WIDTH-1:0] MAX    = WIDTH'(pwm_max(WIDTH));
    localparam logic [WIDTH+1:0] PERIOD = (WIDTH+2)'(pwm_period(WIDTH));

    pwm_state_e       state, state_nxt;
    logic [WIDTH-1:0] prev;
    logic             start;
    logic [WIDTH:0]   eff_duty;
    logic [WIDTH+1:0] sum;

    // prev resets to 0, so a count already parked at MAX after reset still yields one start.
    assign start = (count == MAX) && (prev != MAX);
    assign sum   = {2'b00, count} + {1'b0, eff_duty};

    pwm_duty_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .eff_duty   (eff_duty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next-state gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = WAIT;
                WAIT:    if (start) state_nxt = RUN;
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Gating on the next state makes pwm drop the cycle after en falls and rise on RUN entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev         <= '0;
            period_start <= 1'b0;
            pwm          <= 1'b0;
            period_cnt   <= '0;
        end else begin
            prev         <= count;
            period_start <= start;
            pwm          <= (state_nxt == RUN) && (sum >= PERIOD);
            if (start && (state_nxt == RUN))
                period_cnt <= period_cnt + PCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pwm_downcount_compare.sv
// Directed bench for pwm_downcount_compare at WIDTH = 3: a duty vector table plus
// hand-written sequences for arming, same-cycle transfer, en drop, held count, reset and wrap.
module tb_pwm_downcount_compare;

    localparam int WIDTH  = 3;
    localparam int PCNT_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [WIDTH-1:0]  count;
    logic              en;
    logic [WIDTH:0]    duty_in;
    logic              duty_valid;
    logic              duty_ready;
    logic              pwm;
    logic              period_start;
    logic [PCNT_W-1:0] period_cnt;

    bit cnt_run;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WIDTH:0] duty;
        logic [7:0]     mask;   // bit i = pwm seen after the edge with count = 7 - i
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    pwm_downcount_compare #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .count        (count),
        .en           (en),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm          (pwm),
        .period_start (period_start),
        .period_cnt   (period_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are read 1 ns after the edge, then the upstream counter moves.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cnt_run) count = count - WIDTH'(1);
    endtask

    task automatic wait_count(input logic [WIDTH-1:0] v, output int hi);
        hi = 0;
        for (int i = 0; i < 40 && count != v; i++) begin
            tick();
            hi += int'(pwm);
        end
        if (count != v) begin
            n_fail++;
            $display("FAIL wait_count: count %0d never reached %0d", count, v);
        end
    endtask

    task automatic offer(input logic [WIDTH:0] d);
        duty_valid = 1'b1;
        duty_in    = d;
        tick();
        duty_valid = 1'b0;
    endtask

    task automatic observe(output logic [7:0] mask, output logic ready_first,
                           output logic [PCNT_W-1:0] pc_first);
        mask = '0;
        ready_first = 1'b0;
        pc_first = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            mask[i] = pwm;
            if (i == 0) begin
                ready_first = duty_ready;
                pc_first    = period_cnt;
            end
        end
    endtask

    initial begin
        logic [7:0]        mask;
        logic              rdy;
        logic [PCNT_W-1:0] pc, pc_hold;
        int                hi;
        int                pulses;

        vecs[0] = '{duty: 4'd0,  mask: 8'h00};
        vecs[1] = '{duty: 4'd8,  mask: 8'hFF};
        vecs[2] = '{duty: 4'd12, mask: 8'hFF};
        vecs[3] = '{duty: 4'd1,  mask: 8'h01};
        vecs[4] = '{duty: 4'd5,  mask: 8'h1F};
        vecs[5] = '{duty: 4'd7,  mask: 8'h7F};
        vecs[6] = '{duty: 4'd8,  mask: 8'hFF};

        rst_n = 1'b1; en = 1'b0; duty_valid = 1'b0; duty_in = '0;
        count = 3'd7; cnt_run = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("reset_pwm",          pwm,          0);
        check("reset_period_start", period_start, 0);
        check("reset_period_cnt",   period_cnt,   0);
        check("reset_duty_ready",   duty_ready,   1);
        tick();
        tick();

        // Scenario 1: duty 3 offered on the first (post-reset) start, armed, then run.
        rst_n = 1'b1; en = 1'b1; cnt_run = 1'b1;
        offer(4'd3);
        check("s1_first_start_pulse", period_start, 1);
        check("s1_ready_low",         duty_ready,   0);
        check("s1_pwm_idle",          pwm,          0);
        wait_count(3'd7, hi);
        check("s1_pwm_wait",   hi,         0);
        check("s1_pc_in_wait", period_cnt, 0);
        observe(mask, rdy, pc);
        check("s1_mask_p1",  mask, 8'h07);
        check("s1_pc_p1",    pc,   1);
        check("s1_ready_p1", rdy,  1);
        observe(mask, rdy, pc);
        check("s1_mask_p2", mask, 8'h07);
        check("s1_pc_p2",   pc,   2);

        // Scenario 2 / table: each duty applies from the start after acceptance.
        foreach (vecs[k]) begin
            wait_count(3'd3, hi);
            offer(vecs[k].duty);
            check($sformatf("vec%0d_ready_low", k), duty_ready, 0);
            wait_count(3'd7, hi);
            pc_hold = period_cnt;
            observe(mask, rdy, pc);
            check($sformatf("vec%0d_mask", k),     mask, vecs[k].mask);
            check($sformatf("vec%0d_ready_up", k), rdy,  1);
            check($sformatf("vec%0d_pc_step", k),  pc,   pc_hold + 8'd1);
        end

        // Scenario 3: duty 2 offered on the start edge; old duty 8 runs this period.
        wait_count(3'd7, hi);
        offer(4'd2);
        mask = '0;
        mask[0] = pwm;
        for (int i = 1; i < 8; i++) begin
            tick();
            mask[i] = pwm;
        end
        check("s3_old_duty_mask",  mask,       8'hFF);
        check("s3_ready_held_low", duty_ready, 0);
        observe(mask, rdy, pc);
        check("s3_new_duty_mask", mask, 8'h03);
        check("s3_ready_up",      rdy,  1);

        // Scenario 4: en dropped while high, re-raised mid-period.
        wait_count(3'd7, hi);
        tick();
        check("s4_pwm_high", pwm, 1);
        en = 1'b0;
        tick();
        check("s4_pwm_drop", pwm, 0);
        pc_hold = period_cnt;
        wait_count(3'd7, hi);
        check("s4_pwm_idle", hi, 0);
        tick();
        check("s4_start_in_idle", period_start, 1);
        check("s4_pc_hold",       period_cnt,   pc_hold);
        wait_count(3'd3, hi);
        en = 1'b1;
        wait_count(3'd7, hi);
        check("s4_pwm_wait",  hi,         0);
        check("s4_pc_wait",   period_cnt, pc_hold);
        tick();
        check("s4_pwm_rearm", pwm,        1);
        check("s4_pc_rearm",  period_cnt, pc_hold + 8'd1);

        // Scenario 5: upstream count parked at 7 for 4 cycles.
        wait_count(3'd7, hi);
        pc_hold = period_cnt;
        cnt_run = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) cnt_run = 1'b1;
            tick();
            pulses += int'(period_start);
        end
        check("s5_one_pulse", pulses,     1);
        check("s5_pc_step",   period_cnt, pc_hold + 8'd1);

        // Scenario 6: async reset while pwm is high and a duty is pending.
        wait_count(3'd7, hi);
        offer(4'd8);
        tick();
        check("s6_pre_pwm",   pwm,        1);
        check("s6_pre_ready", duty_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_pwm",   pwm,          0);
        check("s6_async_ps",    period_start, 0);
        check("s6_async_pc",    period_cnt,   0);
        check("s6_async_ready", duty_ready,   1);
        cnt_run = 1'b0;
        count = 3'd7;
        tick();
        tick();
        rst_n = 1'b1;
        cnt_run = 1'b1;
        check("s6_rel_ready", duty_ready, 1);
        tick();
        hi = int'(pwm);
        check("s6_rel_start", period_start, 1);
        wait_count(3'd7, pulses);
        check("s6_pwm_wait", hi + pulses, 0);
        observe(mask, rdy, pc);
        check("s6_zero_duty_mask", mask, 8'h00);
        check("s6_pc_rearm",       pc,   1);
        wait_count(3'd3, hi);
        offer(4'd8);
        wait_count(3'd7, hi);
        tick();
        check("s6_reload_pwm", pwm, 1);

        // period_cnt wraps 255 -> 0.
        for (int i = 0; i < 2600 && period_cnt != 8'd255; i++) tick();
        check("wrap_reach_255", period_cnt, 8'd255);
        wait_count(3'd7, hi);
        tick();
        check("wrap_to_zero", period_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
